// File: rtl/cnn_layer_accel_arb_pkg.sv
// Shared types and helpers for the PE packet arbiter and its round-robin picker.
package cnn_layer_accel_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Bit position of the LAST flag inside a flit of the given width.
    function automatic int LAST_BIT(input int width);
        return width - 1;
    endfunction

    // Ceiling log2, never below 1 so a source index always has at least one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cnn_layer_accel_rr_picker.sv
// Combinational round-robin priority picker: the winner is the first requester
// found searching from ptr_i upward, wrapping modulo NUM_REQ. Indices at or
// above NUM_REQ are never produced.
module cnn_layer_accel_rr_picker #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] ptr_i,
    output logic                 any_req_o,
    output logic [IDX_WIDTH-1:0] winner_o
);

    assign any_req_o = |req_i;

    // Pick the requester at the smallest circular distance from the pointer.
    always_comb begin
        int p;
        int d;
        int best;
        p        = int'(ptr_i);
        d        = 0;
        best     = NUM_REQ;
        winner_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_i[i]) begin
                d = (i >= p) ? (i - p) : (i + NUM_REQ - p);
                if (d < best) begin
                    best     = d;
                    winner_o = IDX_WIDTH'(i);
                end
            end
        end
    end

endmodule

// File: rtl/cnn_layer_accel_pe_pkt_arbiter.sv
// Round-robin, packet-locked arbiter merging per-PE flit streams into one
// registered output channel. A grant is held from a packet's first flit to its
// LAST-flagged flit, so packets never interleave on the output.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no packet in flight; round-robin search picks the next PE
//   ST_LOCKED | owner_q is mid-packet; only its flits are accepted
module cnn_layer_accel_pe_pkt_arbiter
    import cnn_layer_accel_arb_pkg::*;
#(
    parameter int C_PACKET_WIDTH = 66,
    parameter int C_NUM_PE       = 4,
    localparam int C_SRC_WIDTH   = clog2_min1(C_NUM_PE)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [C_NUM_PE-1:0]                in_valid,
    output logic [C_NUM_PE-1:0]                in_accept,
    input  logic [C_PACKET_WIDTH*C_NUM_PE-1:0] in_data,
    output logic                               out_valid,
    input  logic                               out_accept,
    output logic [C_PACKET_WIDTH-1:0]          out_data,
    output logic [C_SRC_WIDTH-1:0]             out_src,
    output logic                               busy
);

    localparam int C_LAST = LAST_BIT(C_PACKET_WIDTH);

    arb_state_e                state_q, state_d;
    logic [C_SRC_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [C_SRC_WIDTH-1:0]    owner_q, owner_d;
    logic                      out_valid_q, out_valid_d;
    logic [C_PACKET_WIDTH-1:0] out_data_q, out_data_d;
    logic [C_SRC_WIDTH-1:0]    out_src_q, out_src_d;

    logic                      any_req;
    logic [C_SRC_WIDTH-1:0]    winner;
    logic                      slot_free;
    logic [C_SRC_WIDTH-1:0]    sel_src;
    logic                      owner_valid;
    logic                      sel_valid;
    logic [C_PACKET_WIDTH-1:0] sel_data;
    logic                      take;
    logic [C_SRC_WIDTH-1:0]    sel_src_inc;

    cnn_layer_accel_rr_picker #(
        .NUM_REQ   (C_NUM_PE),
        .IDX_WIDTH (C_SRC_WIDTH)
    ) u_picker (
        .req_i     (in_valid),
        .ptr_i     (rr_ptr_q),
        .any_req_o (any_req),
        .winner_o  (winner)
    );

    assign slot_free   = !out_valid_q || out_accept;
    assign sel_src     = (state_q == ST_LOCKED) ? owner_q : winner;
    assign sel_valid   = (state_q == ST_LOCKED) ? owner_valid : any_req;
    // Gated by rst so no PE sees a handshake while the arbiter is held in reset.
    assign take        = rst && sel_valid && slot_free;
    assign sel_src_inc = (sel_src == C_SRC_WIDTH'(C_NUM_PE - 1)) ? '0
                                                                 : sel_src + C_SRC_WIDTH'(1);

    // Steer the selected PE's valid and flit, and decode the one-hot accept.
    // in_data only feeds the output register, never in_accept.
    always_comb begin
        owner_valid = 1'b0;
        sel_data    = '0;
        in_accept   = '0;
        for (int i = 0; i < C_NUM_PE; i++) begin
            if (owner_q == C_SRC_WIDTH'(i)) begin
                owner_valid = in_valid[i];
            end
            if (sel_src == C_SRC_WIDTH'(i)) begin
                sel_data     = in_data[i*C_PACKET_WIDTH +: C_PACKET_WIDTH];
                in_accept[i] = take;
            end
        end
    end

    // Next-state logic for the FSM, round-robin pointer and output register.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_src_d   = sel_src;
            if (sel_data[C_LAST]) begin
                rr_ptr_d = sel_src_inc;
                state_d  = ST_IDLE;
            end else begin
                owner_d  = sel_src;
                state_d  = ST_LOCKED;
            end
        end else if (out_accept) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers; reset drops any partial packet and output flit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q == ST_LOCKED);

endmodule
